// File: rtl/ram_sync_dp.sv
// Synchronous dual-port work RAM: port A read/write (read-first), port B read-only,
// hardware clear sweep after reset or clr_req. Optional RAM_BYPASS_EN: A-write to B-read forwarding.
module ram_sync_dp #(
  parameter int unsigned    AW        = 10,
  parameter int unsigned    DW        = 8,
  parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic          a_cs_n,
  input  logic          a_we_n,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout,
  input  logic          b_cs_n,
  input  logic          clr_req,
  output logic          busy
);

  localparam int unsigned DEPTH    = 2 ** AW;
  localparam logic        ST_CLEAR = 1'b0;
  localparam logic        ST_IDLE  = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];

  logic          state;
  logic          state_next;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_next;
  logic          clearing_c;
  logic          a_wr_c;
  logic [DW-1:0] b_rd_c;

  assign clearing_c = (state == ST_CLEAR);
  assign a_wr_c     = !clearing_c && !a_cs_n && !a_we_n;

  // Sweep sequencer: one location per cycle, back to IDLE after the last address.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_next = cnt + AW'(1);
        if (cnt == LAST_ADDR) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next == ST_CLEAR);
    end
  end

  // Storage has no reset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (clearing_c) begin
      mem[cnt] <= CLEAR_VAL;
    end else if (a_wr_c) begin
      mem[a_addr] <= a_din;
    end
  end

`ifdef RAM_BYPASS_EN
  always_comb begin
    b_rd_c = mem[b_addr];
    if (a_wr_c && (a_addr == b_addr)) b_rd_c = a_din;
  end
`else
  always_comb begin
    b_rd_c = mem[b_addr];
  end
`endif

  // Registered read ports; a deselected port holds its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      if (!a_cs_n) a_dout <= clearing_c ? '0 : mem[a_addr];
      if (!b_cs_n) b_dout <= clearing_c ? '0 : b_rd_c;
    end
  end

endmodule

// File: tb/tb_ram_sync_dp.sv
// Scoreboard bench for ram_sync_dp (AW=4, DW=8); a second instance with CLEAR_VAL=8'h20
// covers reset in the middle of a sweep.
module tb_ram_sync_dp;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic [DW-1:0] a_dout;
  logic          a_cs_n;
  logic          a_we_n;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_dout;
  logic          b_cs_n;
  logic          clr_req;
  logic          busy;

  logic          rst2_n;
  logic [AW-1:0] a2_addr;
  logic [DW-1:0] a2_dout;
  logic          a2_cs_n;
  logic [AW-1:0] b2_addr;
  logic [DW-1:0] b2_dout;
  logic          b2_cs_n;
  logic          busy2;

  int n_total;
  int n_bad;

  logic [DW-1:0] mem_m [16];
  int            clr_left;
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;
  exp_t          q[$];

  ram_sync_dp #(.AW(AW), .DW(DW), .CLEAR_VAL(8'h00)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_cs_n(a_cs_n), .a_we_n(a_we_n),
    .b_addr(b_addr), .b_dout(b_dout), .b_cs_n(b_cs_n),
    .clr_req(clr_req), .busy(busy)
  );

  ram_sync_dp #(.AW(AW), .DW(DW), .CLEAR_VAL(8'h20)) dut2 (
    .clk(clk), .reset_n(rst2_n),
    .a_addr(a2_addr), .a_din(8'h99), .a_dout(a2_dout), .a_cs_n(a2_cs_n), .a_we_n(1'b1),
    .b_addr(b2_addr), .b_dout(b2_dout), .b_cs_n(b2_cs_n),
    .clr_req(1'b0), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic on dut: predict, push, clock, pop and compare.
  task automatic step(input logic acs, input logic awe, input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad, input logic bcs, input logic [AW-1:0] ba,
                      input logic clr);
    exp_t e;
    exp_t r;
    a_cs_n = acs; a_we_n = awe; a_addr = aa; a_din = ad;
    b_cs_n = bcs; b_addr = ba; clr_req = clr;
    e.a = last_a;
    e.b = last_b;
    if (clr_left > 0) begin
      if (!acs) e.a = 8'h00;
      if (!bcs) e.b = 8'h00;
      clr_left--;
    end else begin
      if (!acs) e.a = mem_m[aa];
      if (!bcs) begin
        e.b = mem_m[ba];
`ifdef RAM_BYPASS_EN
        if (!acs && !awe && aa == ba) e.b = ad;
`endif
      end
      if (!acs && !awe) mem_m[aa] = ad;
      if (clr) begin
        clr_left = 16;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
      end
    end
    e.busy = (clr_left > 0);
    q.push_back(e);
    @(posedge clk);
    #1;
    r = q.pop_front();
    check("a_dout", 32'(a_dout), 32'(r.a));
    check("b_dout", 32'(b_dout), 32'(r.b));
    check("busy", 32'(busy), 32'(r.busy));
    last_a = r.a;
    last_b = r.b;
    clr_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 1'b0);
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    reset_n = 1'b0; rst2_n = 1'b0;
    a_addr = '0; a_din = '0; a_cs_n = 1'b1; a_we_n = 1'b1;
    b_addr = '0; b_cs_n = 1'b1; clr_req = 1'b0;
    a2_addr = '0; a2_cs_n = 1'b1; b2_addr = '0; b2_cs_n = 1'b1;
    clr_left = 16; last_a = 8'h00; last_b = 8'h00;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'hxx;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_a_dout", 32'(a_dout), 32'd0);
    check("rst_b_dout", 32'(b_dout), 32'd0);
    reset_n = 1'b1;

    // Power-up sweep, then every location reads the clear value.
    idle(16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 8'h00, 1'b0, 4'(15 - i), 1'b0);

    // Read-first write, then readback.
    step(1'b0, 1'b0, 4'h3, 8'hA5, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h3, 8'h00, 1'b1, 4'h0, 1'b0);

    // Collision: A writes while B reads the same address, then B re-reads.
    step(1'b0, 1'b0, 4'h3, 8'h5A, 1'b0, 4'h3, 1'b0);
    step(1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 4'h3, 1'b0);

    // Deselect hold.
    step(1'b0, 1'b0, 4'h3, 8'hA5, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 4'h3, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 7), 8'h11, 1'b1, 4'(i), 1'b0);

    // Fill with FF, request a clear; a mid-sweep write and clr_req are ignored.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'(i), 8'hFF, 1'b1, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 5)      step(1'b0, 1'b0, 4'h3, 8'h77, 1'b0, 4'h3, 1'b0);
      else if (i == 9) step(1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1);
      else             step(1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 4'(i), 1'b0);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 8'h00, 1'b0, 4'(i), 1'b0);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)),
           8'($urandom), 1'($urandom_range(1)), 4'($urandom_range(15)), 1'b0);

    // Second instance: reset asserted while the sweep is at address 7.
    rst2_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("d2_busy_mid", 32'(busy2), 32'd1);
    rst2_n = 1'b0;
    #1;
    check("d2_rst_busy", 32'(busy2), 32'd1);
    check("d2_rst_a", 32'(a2_dout), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst2_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      check("d2_busy", 32'(busy2), (i < 16) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      exp_t r;
      a2_cs_n = 1'b0; a2_addr = 4'(i);
      b2_cs_n = 1'b0; b2_addr = 4'(15 - i);
      e.a = 8'h20; e.b = 8'h20; e.busy = 1'b0;
      q.push_back(e);
      @(posedge clk);
      #1;
      r = q.pop_front();
      check("d2_a_dout", 32'(a2_dout), 32'(r.a));
      check("d2_b_dout", 32'(b2_dout), 32'(r.b));
      check("d2_busy_idle", 32'(busy2), 32'(r.busy));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_sync_dp.md
Name: ram_sync_dp

Overview:
- Parametrised synchronous dual-port RAM; the next generation of the game-board work RAMs.
- Port A: CPU read/write port. Port B: read-only port for the video/motion-object fetch path.
- Registered reads and a hardware clear sequencer fill every location with CLEAR_VAL after reset or on request. Memory initialisation is therefore defined in silicon, not only in simulation.
- Sits between the CPU address decode and the playfield/sprite fetch logic.

Parameters:
- AW, 10, address width; depth = 2**AW.
- DW, 8, data width.
- CLEAR_VAL, 0, DW-bit value written to every location by the clear sweep.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- a_addr  input  AW  port A address.
- a_din  input  DW  port A write data.
- a_dout  output  DW  port A registered read data.
- a_cs_n  input  1  port A chip select, active low.
- a_we_n  input  1  port A write enable, active low; write when a_cs_n=0 and a_we_n=0.
- b_addr  input  AW  port B address.
- b_dout  output  DW  port B registered read data.
- b_cs_n  input  1  port B chip select, active low; read only.
- clr_req  input  1  single-cycle pulse; starts a clear sweep when sampled in IDLE.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset is asynchronous on reset_n=0 and forces:
  - state=CLEAR, clear counter=0, busy=1, a_dout=0, b_dout=0.
  - Memory contents are not touched by reset itself.
- States:
  - CLEAR: each cycle writes CLEAR_VAL to mem[counter], then counter+1.
    - Leaves for IDLE on the edge that writes address 2**AW-1; the counter wraps to 0.
    - busy is high for exactly 2**AW cycles after reset_n rises.
  - IDLE: normal operation, busy=0. clr_req=1 sampled → CLEAR with counter=0, busy=1 from the next cycle.
- During CLEAR:
  - Port A writes are dropped.
  - a_dout and b_dout update to 0 on any selected read.
  - clr_req is ignored; a sweep is never restarted by clr_req.
- reset_n asserted mid-sweep restarts the sweep from address 0 after release.
- Port A read (a_cs_n=0, a_we_n=1): a_dout = mem[a_addr] on the next edge. Latency 1.
- Port A write: mem[a_addr] <= a_din. a_dout also updates with the old contents (read-first).
- Port B read (b_cs_n=0): b_dout = mem[b_addr] on the next edge. Latency 1.
- Deselected port (cs_n=1): its dout holds its previous value.
- Collision (port A write and port B read to the same address in the same cycle): b_dout returns old data unless RAM_BYPASS_EN is defined.
- Address arithmetic: counter is AW bits; no out-of-range addresses exist.

Optional Feature:
- Macro: RAM_BYPASS_EN.
- Defined: on a collision as above, b_dout takes a_din (write-through forwarding to the video port).
  - Port A stays read-first.
  - No forwarding during CLEAR.
- Undefined: b_dout returns the pre-write contents; no comparator logic is synthesised.

Test Plan (AW=4, DW=8, CLEAR_VAL=8'h00 unless stated):
- Power-up: reset_n low 3 cycles, then high → busy high exactly 16 cycles. Afterwards port A reads of addresses 0..15 all return 8'h00 one cycle after address presentation.
- Port A write 8'hA5 to 4'h3, next cycle read 4'h3 → a_dout=8'hA5 after 1 cycle. The write cycle itself shows a_dout = old value 8'h00.
- Port B read of 4'h3 while port A writes 8'h5A to 4'h3:
  - b_dout=8'hA5 without RAM_BYPASS_EN.
  - b_dout=8'h5A with RAM_BYPASS_EN.
  - Next B read returns 8'h5A in both builds.
- Write 8'hFF to all 16 addresses, pulse clr_req. Expected:
  - busy rises next cycle and stays high 16 cycles.
  - A write of 8'h77 issued mid-sweep is dropped.
  - All locations read 8'h00 afterwards.
- With CLEAR_VAL=8'h20: assert reset_n low at sweep address 7, release → sweep restarts at 0, busy high 16 full cycles, all locations read 8'h20.
- Deselect hold: read 4'h3 (8'hA5), then hold a_cs_n=1 and b_cs_n=1 for 5 cycles while changing addresses → a_dout and b_dout stay 8'hA5.
